// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store width codes and memory-access FSM encoding.
package rv32i_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  // Halfword needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3[1:0])
      2'b01:   return lane[0];
      2'b10:   return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_align.sv
// Combinational load extract (sign/zero extend) and sub-word store merge.
module mem_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] sdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    load_data_o = rdata_i;
    case (funct3_i)
      LB:      load_data_o = {{24{byte_sel[7]}}, byte_sel};
      LBU:     load_data_o = {24'h000000, byte_sel};
      LH:      load_data_o = {{16{half_sel[15]}}, half_sel};
      LHU:     load_data_o = {16'h0000, half_sel};
      default: load_data_o = rdata_i;
    endcase

    store_data_o = rdata_i;
    case (funct3_i)
      SB: store_data_o[{lane_i, 3'b000} +: 8] = sdata_i[7:0];
      SH: begin
        if (lane_i[1]) store_data_o[31:16] = sdata_i[15:0];
        else           store_data_o[15:0]  = sdata_i[15:0];
      end
      default: store_data_o = sdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// RV32I memory-access stage: loads, read-modify-write sub-word stores, pass-through.
// Optional MEM_MISALIGN_TRAP_EN adds mem_misalign_o and traps unaligned halfword/word accesses.
module mem_access
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        state_mem_i,
  input  logic        ex_load_i,
  input  logic        ex_store_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic [31:0] ex_addr_i,
  input  logic [31:0] ex_sdata_i,
  input  logic        ex_reg_wr_en_i,
  input  logic [4:0]  ex_reg_addr_i,
  input  logic [31:0] ex_reg_data_i,
  input  logic        ex_csr_wr_en_i,
  input  logic [11:0] ex_csr_addr_i,
  input  logic [31:0] ex_csr_data_i,
  output logic        dmem_req_o,
  output logic [31:0] dmem_addr_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        mem_done_o,
  output logic        mem_buserr_o,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        mem_misalign_o,
`endif
  output logic        wrbk_reg_wr_en_o,
  output logic [4:0]  wrbk_reg_addr_o,
  output logic [31:0] wrbk_reg_data_o,
  output logic        wrbk_mem_wr_en_o,
  output logic [31:0] wrbk_mem_addr_o,
  output logic [31:0] wrbk_mem_data_o,
  output logic        wrbk_csr_wr_en_o,
  output logic [11:0] wrbk_csr_addr_o,
  output logic [31:0] wrbk_csr_data_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  mem_state_e state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic start, go_done, tmo_abort, misalign_hit, tmo_last, idle;

  logic        load_q, store_q, reg_wr_en_q, csr_wr_en_q;
  logic [2:0]  funct3_q;
  logic [4:0]  reg_addr_q;
  logic [11:0] csr_addr_q;
  logic [31:0] addr_q, sdata_q, reg_data_q, csr_data_q;

  logic        src_load, src_store, src_reg_wr_en, src_csr_wr_en;
  logic [2:0]  src_funct3;
  logic [4:0]  src_reg_addr;
  logic [11:0] src_csr_addr;
  logic [31:0] src_addr, src_sdata, src_reg_data, src_csr_data;
  logic [31:0] load_data, store_data;

  // Immediate completions finish on the start edge, before capture regs are loaded,
  // so write-back is built from the live inputs in IDLE and the captured copy otherwise.
  assign idle          = (state_q == IDLE);
  assign src_load      = idle ? ex_load_i      : load_q;
  assign src_store     = idle ? ex_store_i     : store_q;
  assign src_funct3    = idle ? ex_funct3_i    : funct3_q;
  assign src_addr      = idle ? ex_addr_i      : addr_q;
  assign src_sdata     = idle ? ex_sdata_i     : sdata_q;
  assign src_reg_wr_en = idle ? ex_reg_wr_en_i : reg_wr_en_q;
  assign src_reg_addr  = idle ? ex_reg_addr_i  : reg_addr_q;
  assign src_reg_data  = idle ? ex_reg_data_i  : reg_data_q;
  assign src_csr_wr_en = idle ? ex_csr_wr_en_i : csr_wr_en_q;
  assign src_csr_addr  = idle ? ex_csr_addr_i  : csr_addr_q;
  assign src_csr_data  = idle ? ex_csr_data_i  : csr_data_q;

  assign tmo_last    = (cnt_q == TMO_LAST);
  assign dmem_req_o  = (state_q == REQ);
  assign dmem_addr_o = {addr_q[31:2], 2'b00};

  mem_align u_align (
    .funct3_i     (src_funct3),
    .lane_i       (src_addr[1:0]),
    .rdata_i      (dmem_rdata_i),
    .sdata_i      (src_sdata),
    .load_data_o  (load_data),
    .store_data_o (store_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    start        = 1'b0;
    go_done      = 1'b0;
    tmo_abort    = 1'b0;
    misalign_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (state_mem_i) begin
          start = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
          misalign_hit = (ex_load_i || ex_store_i) && is_misaligned(ex_funct3_i, ex_addr_i[1:0]);
`endif
          if (!misalign_hit && (ex_load_i || (ex_store_i && ex_funct3_i != SW))) begin
            state_d = REQ;
          end else begin
            state_d = DONE;
            go_done = 1'b1;
          end
        end
      end
      REQ: begin
        if (tmo_last) begin
          state_d   = DONE;
          go_done   = 1'b1;
          tmo_abort = 1'b1;
        end else if (dmem_gnt_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          state_d = DONE;
          go_done = 1'b1;
        end else if (tmo_last) begin
          state_d   = DONE;
          go_done   = 1'b1;
          tmo_abort = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || start) cnt_q <= '0;
    else if (state_q == REQ || state_q == WAIT) cnt_q <= cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      load_q      <= 1'b0;
      store_q     <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      sdata_q     <= '0;
      reg_wr_en_q <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      csr_wr_en_q <= 1'b0;
      csr_addr_q  <= '0;
      csr_data_q  <= '0;
    end else if (start) begin
      load_q      <= ex_load_i;
      store_q     <= ex_store_i;
      funct3_q    <= ex_funct3_i;
      addr_q      <= ex_addr_i;
      sdata_q     <= ex_sdata_i;
      reg_wr_en_q <= ex_reg_wr_en_i;
      reg_addr_q  <= ex_reg_addr_i;
      reg_data_q  <= ex_reg_data_i;
      csr_wr_en_q <= ex_csr_wr_en_i;
      csr_addr_q  <= ex_csr_addr_i;
      csr_data_q  <= ex_csr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_done_o       <= 1'b0;
      mem_buserr_o     <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mem_misalign_o   <= 1'b0;
`endif
      wrbk_reg_wr_en_o <= 1'b0;
      wrbk_reg_addr_o  <= '0;
      wrbk_reg_data_o  <= '0;
      wrbk_mem_wr_en_o <= 1'b0;
      wrbk_mem_addr_o  <= '0;
      wrbk_mem_data_o  <= '0;
      wrbk_csr_wr_en_o <= 1'b0;
      wrbk_csr_addr_o  <= '0;
      wrbk_csr_data_o  <= '0;
    end else begin
      mem_done_o   <= go_done;
      mem_buserr_o <= tmo_abort;
`ifdef MEM_MISALIGN_TRAP_EN
      mem_misalign_o <= misalign_hit;
`endif
      if (go_done) begin
        wrbk_reg_wr_en_o <= src_reg_wr_en && !src_store && !tmo_abort && !misalign_hit;
        wrbk_reg_addr_o  <= src_reg_addr;
        wrbk_reg_data_o  <= src_load ? load_data : src_reg_data;
        wrbk_mem_wr_en_o <= src_store && !tmo_abort && !misalign_hit;
        wrbk_mem_addr_o  <= {src_addr[31:2], 2'b00};
        wrbk_mem_data_o  <= src_store ? store_data : '0;
        wrbk_csr_wr_en_o <= src_csr_wr_en;
        wrbk_csr_addr_o  <= src_csr_addr;
        wrbk_csr_data_o  <= src_csr_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with an arithmetic reference model and per-cycle output compare.
module tb_mem_access;
  import rv32i_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i, state_mem_i, ex_load_i, ex_store_i;
  logic [2:0]  ex_funct3_i;
  logic [31:0] ex_addr_i, ex_sdata_i, ex_reg_data_i, ex_csr_data_i;
  logic        ex_reg_wr_en_i, ex_csr_wr_en_i;
  logic [4:0]  ex_reg_addr_i;
  logic [11:0] ex_csr_addr_i;
  logic        dmem_req_o, dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_addr_o, dmem_rdata_i;
  logic        mem_done_o, mem_buserr_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        mem_misalign_o;
`endif
  logic        wrbk_reg_wr_en_o, wrbk_mem_wr_en_o, wrbk_csr_wr_en_o;
  logic [4:0]  wrbk_reg_addr_o;
  logic [31:0] wrbk_reg_data_o, wrbk_mem_addr_o, wrbk_mem_data_o, wrbk_csr_data_o;
  logic [11:0] wrbk_csr_addr_o;

  mem_access #(.TIMEOUT_CYC(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .state_mem_i(state_mem_i),
    .ex_load_i(ex_load_i), .ex_store_i(ex_store_i), .ex_funct3_i(ex_funct3_i),
    .ex_addr_i(ex_addr_i), .ex_sdata_i(ex_sdata_i),
    .ex_reg_wr_en_i(ex_reg_wr_en_i), .ex_reg_addr_i(ex_reg_addr_i), .ex_reg_data_i(ex_reg_data_i),
    .ex_csr_wr_en_i(ex_csr_wr_en_i), .ex_csr_addr_i(ex_csr_addr_i), .ex_csr_data_i(ex_csr_data_i),
    .dmem_req_o(dmem_req_o), .dmem_addr_o(dmem_addr_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .mem_done_o(mem_done_o), .mem_buserr_o(mem_buserr_o),
`ifdef MEM_MISALIGN_TRAP_EN
    .mem_misalign_o(mem_misalign_o),
`endif
    .wrbk_reg_wr_en_o(wrbk_reg_wr_en_o), .wrbk_reg_addr_o(wrbk_reg_addr_o), .wrbk_reg_data_o(wrbk_reg_data_o),
    .wrbk_mem_wr_en_o(wrbk_mem_wr_en_o), .wrbk_mem_addr_o(wrbk_mem_addr_o), .wrbk_mem_data_o(wrbk_mem_data_o),
    .wrbk_csr_wr_en_o(wrbk_csr_wr_en_o), .wrbk_csr_addr_o(wrbk_csr_addr_o), .wrbk_csr_data_o(wrbk_csr_data_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: plain shift/mask arithmetic on the 32-bit word.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    logic [31:0] b, h;
    b = (rdata >> (8 * addr[1:0])) & 32'hFF;
    h = (rdata >> (16 * addr[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b ^ 32'h80) - 32'h80;
      3'b100:  return b;
      3'b001:  return (h ^ 32'h8000) - 32'h8000;
      3'b101:  return h;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] old, input logic [31:0] sdata);
    logic [31:0] m;
    case (f3)
      3'b000: begin
        m = 32'hFF << (8 * addr[1:0]);
        return (old & ~m) | ((sdata & 32'hFF) << (8 * addr[1:0]));
      end
      3'b001: begin
        m = 32'hFFFF << (16 * addr[1]);
        return (old & ~m) | ((sdata & 32'hFFFF) << (16 * addr[1]));
      end
      default: return sdata;
    endcase
  endfunction

  // Expectations for the next completion, consumed by the compare process.
  logic        pending = 1'b0;
  logic [31:0] exp_req_addr;
  logic        exp_reg_wr_en, exp_mem_wr_en, exp_csr_wr_en, exp_err, exp_mis;
  logic        chk_reg_data, chk_mem_data;
  logic [4:0]  exp_reg_addr;
  logic [31:0] exp_reg_data, exp_mem_addr, exp_mem_data, exp_csr_data;
  logic [11:0] exp_csr_addr;

  always @(negedge clk_i) begin
    if (dmem_req_o) chk("req_addr", dmem_addr_o, exp_req_addr);
    if (!mem_done_o) chk("buserr_without_done", {31'b0, mem_buserr_o}, 32'h0);
    if (mem_done_o) begin
      chk("done_expected", {31'b0, pending}, 32'h1);
      if (pending) begin
        pending = 1'b0;
        chk("reg_wr_en", {31'b0, wrbk_reg_wr_en_o}, {31'b0, exp_reg_wr_en});
        chk("reg_addr", {27'b0, wrbk_reg_addr_o}, {27'b0, exp_reg_addr});
        chk("mem_wr_en", {31'b0, wrbk_mem_wr_en_o}, {31'b0, exp_mem_wr_en});
        chk("mem_addr", wrbk_mem_addr_o, exp_mem_addr);
        chk("csr_wr_en", {31'b0, wrbk_csr_wr_en_o}, {31'b0, exp_csr_wr_en});
        chk("csr_addr", {20'b0, wrbk_csr_addr_o}, {20'b0, exp_csr_addr});
        chk("csr_data", wrbk_csr_data_o, exp_csr_data);
        chk("buserr", {31'b0, mem_buserr_o}, {31'b0, exp_err});
        if (chk_reg_data) chk("reg_data", wrbk_reg_data_o, exp_reg_data);
        if (chk_mem_data) chk("mem_data", wrbk_mem_data_o, exp_mem_data);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("misalign", {31'b0, mem_misalign_o}, {31'b0, exp_mis});
`endif
      end
    end
  end

  task automatic check_zero(input string nm);
    chk({nm, "_req"}, {31'b0, dmem_req_o}, 32'h0);
    chk({nm, "_daddr"}, dmem_addr_o, 32'h0);
    chk({nm, "_done"}, {30'b0, mem_done_o, mem_buserr_o}, 32'h0);
    chk({nm, "_wren"}, {29'b0, wrbk_reg_wr_en_o, wrbk_mem_wr_en_o, wrbk_csr_wr_en_o}, 32'h0);
    chk({nm, "_raddr"}, {27'b0, wrbk_reg_addr_o}, 32'h0);
    chk({nm, "_rdata"}, wrbk_reg_data_o, 32'h0);
    chk({nm, "_maddr"}, wrbk_mem_addr_o, 32'h0);
    chk({nm, "_mdata"}, wrbk_mem_data_o, 32'h0);
    chk({nm, "_caddr"}, {20'b0, wrbk_csr_addr_o}, 32'h0);
    chk({nm, "_cdata"}, wrbk_csr_data_o, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk({nm, "_mis"}, {31'b0, mem_misalign_o}, 32'h0);
`endif
  endtask

  task automatic drive_fields(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sdata, input int id);
    ex_load_i      = ld;
    ex_store_i     = st;
    ex_funct3_i    = f3;
    ex_addr_i      = addr;
    ex_sdata_i     = sdata;
    ex_reg_wr_en_i = 1'b1;
    ex_reg_addr_i  = 5'(id);
    ex_reg_data_i  = 32'hA000_0000 + 32'(id);
    ex_csr_wr_en_i = id[0];
    ex_csr_addr_i  = 12'h300 + 12'(id);
    ex_csr_data_i  = 32'hC000_0000 + 32'(id);
  endtask

  int done_cyc;
  logic saw_req;

  task automatic do_op(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [31:0] rdata,
                       input int gnt_dly, input int rv_dly, input int id);
    logic need_req, mis;
    int exp_lat, req_wait, rv_wait;
    logic granted;
    @(posedge clk_i); #1;
    mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis = (ld || st) && ((f3[1:0] == 2'b01 && addr[0]) || (f3[1:0] == 2'b10 && addr[1:0] != 2'b00));
`endif
    need_req = !mis && (ld || (st && f3 != 3'b010));
    exp_err  = need_req && (gnt_dly + rv_dly + 2 > 16);
    exp_lat  = !need_req ? 1 : (exp_err ? 17 : 3 + gnt_dly + rv_dly);
    exp_mis  = mis;
    exp_req_addr  = addr & 32'hFFFF_FFFC;
    exp_reg_wr_en = !st && !exp_err && !mis;
    exp_reg_addr  = 5'(id);
    exp_reg_data  = ld ? model_load(f3, addr, rdata) : 32'hA000_0000 + 32'(id);
    exp_mem_wr_en = st && !exp_err && !mis;
    exp_mem_addr  = addr & 32'hFFFF_FFFC;
    exp_mem_data  = model_store(f3, addr, rdata, sdata);
    exp_csr_wr_en = id[0];
    exp_csr_addr  = 12'h300 + 12'(id);
    exp_csr_data  = 32'hC000_0000 + 32'(id);
    chk_reg_data  = !st && !exp_err && !mis;
    chk_mem_data  = st && !exp_err && !mis;
    pending = 1'b1;

    drive_fields(ld, st, f3, addr, sdata, id);
    state_mem_i = 1'b1;
    done_cyc = -1; saw_req = 1'b0; granted = 1'b0; req_wait = 0; rv_wait = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk_i); #1;
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h5A5A_5A5A;
      // A restart strobe and altered fields while busy must be ignored.
      if (cyc == 1) drive_fields(!ld, !st, ~f3, ~addr, ~sdata, id + 7);
      if (cyc == 2) state_mem_i = 1'b0;
      if (mem_done_o) begin
        done_cyc = cyc;
        break;
      end
      if (dmem_req_o) begin
        saw_req = 1'b1;
        if (req_wait >= gnt_dly) begin
          dmem_gnt_i = 1'b1;
          dmem_rvalid_i = 1'b1;  // premature rvalid in the grant cycle
          dmem_rdata_i = 32'hDEAD_BEEF;
          granted = 1'b1;
        end else req_wait++;
      end else if (granted) begin
        if (rv_wait >= rv_dly) begin
          dmem_rvalid_i = 1'b1;
          dmem_rdata_i = rdata;
        end else rv_wait++;
      end
    end
    chk("done_latency", 32'(done_cyc), 32'(exp_lat));
    chk("req_seen", {31'b0, saw_req}, {31'b0, need_req});
    if (state_mem_i) begin
      @(posedge clk_i); #1;
      state_mem_i = 1'b0;
    end
  endtask

  initial begin
    rst_i = 1'b1; state_mem_i = 1'b0;
    drive_fields(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 0);
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    repeat (2) @(posedge clk_i);
    #1 check_zero("reset");
    rst_i = 1'b0;

    do_op(1'b1, 1'b0, LB, 32'h103, 32'h0, 32'h80FF1234, 0, 0, 1);
    chk("t1_lb_data", wrbk_reg_data_o, 32'hFFFFFF80);
    chk("t1_latency", 32'(done_cyc), 32'd3);

    do_op(1'b1, 1'b0, LHU, 32'h102, 32'h0, 32'hBEEF1234, 0, 0, 2);
    chk("t2_lhu_data", wrbk_reg_data_o, 32'h0000BEEF);
    chk("t2_wren", {30'b0, wrbk_reg_wr_en_o, wrbk_mem_wr_en_o}, 32'h2);

    do_op(1'b0, 1'b1, SH, 32'h202, 32'h0000ABCD, 32'h11223344, 0, 1, 3);
    chk("t3_sh_addr", wrbk_mem_addr_o, 32'h200);
    chk("t3_sh_data", wrbk_mem_data_o, 32'hABCD3344);

    do_op(1'b0, 1'b1, SW, 32'h300, 32'h5555AAAA, 32'h0, 0, 0, 4);
    chk("t4_sw_noreq", {31'b0, saw_req}, 32'h0);
    chk("t4_sw_data", wrbk_mem_data_o, 32'h5555AAAA);
    do_op(1'b0, 1'b0, 3'b111, 32'h404, 32'h0, 32'h0, 0, 0, 5);
    chk("t4_alu_data", wrbk_reg_data_o, 32'hA0000005);
    chk("t4_alu_latency", 32'(done_cyc), 32'd1);

    do_op(1'b1, 1'b0, LB,  32'h100, 32'h0, 32'h1234567F, 0, 0, 6);
    do_op(1'b1, 1'b0, LBU, 32'h101, 32'h0, 32'h0000F000, 1, 0, 7);
    do_op(1'b1, 1'b0, LH,  32'h100, 32'h0, 32'h0000_8001, 0, 2, 8);
    do_op(1'b0, 1'b1, SB,  32'h501, 32'h000000EE, 32'hAABBCCDD, 0, 0, 9);
    do_op(1'b0, 1'b1, SH,  32'h500, 32'h00001357, 32'hAABBCCDD, 1, 1, 10);
    do_op(1'b1, 1'b0, LW,  32'h604, 32'h0, 32'hCAFEF00D, 3, 0, 11);
    chk("t5_gnt3_latency", 32'(done_cyc), 32'd6);

    // Reset while waiting for read data: everything clears, no completion follows.
    @(posedge clk_i); #1;
    exp_req_addr = 32'h700;
    drive_fields(1'b1, 1'b0, LW, 32'h700, 32'h0, 12);
    state_mem_i = 1'b1;
    @(posedge clk_i); #1;
    state_mem_i = 1'b0;
    dmem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    dmem_gnt_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check_zero("rst_in_wait");
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i); #1;
      chk("rst_no_done", {30'b0, mem_done_o, dmem_req_o}, 32'h0);
    end
    dmem_rvalid_i = 1'b0;

    do_op(1'b1, 1'b0, LW, 32'h800, 32'h0, 32'h0, 99, 0, 13);
    chk("t5_timeout_err", {31'b0, mem_buserr_o}, 32'h1);
    chk("t5_timeout_wren", {30'b0, wrbk_reg_wr_en_o, wrbk_mem_wr_en_o}, 32'h0);
    chk("t5_timeout_latency", 32'(done_cyc), 32'd17);

    do_op(1'b1, 1'b0, LW, 32'h101, 32'h0, 32'h87654321, 0, 0, 14);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("t6_misalign", {31'b0, mem_misalign_o}, 32'h1);
    chk("t6_noreq", {31'b0, saw_req}, 32'h0);
`else
    chk("t6_aligned_word", wrbk_reg_data_o, 32'h87654321);
    chk("t6_req_seen", {31'b0, saw_req}, 32'h1);
`endif

    @(posedge clk_i); #1;
    chk("final_no_pending", {31'b0, pending}, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
